// File: rtl/led_blink_driver_pkg.sv
// Shared types and constants for the LED blink driver.
// Optional feature macro used by this slice: BLINK_QUEUE_EN.
package led_pkg;

    localparam int unsigned CNT_W = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } led_state_t;

endpackage

// File: rtl/led_blink_driver_if.sv
// Event/status bundle between the FPU control logic and the LED blink driver.
interface led_blink_driver_if #(
    parameter int unsigned PEND_W = 4
);

    logic              event_in;
    logic              clr_in;
    logic              led_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output event_in, clr_in,
        input  led_out, busy, pending, overflow
    );

    modport slave (
        input  event_in, clr_in,
        output led_out, busy, pending, overflow
    );

endinterface

// File: rtl/led_blink_driver_sat_counter.sv
// Up/down counter that saturates at all-ones and never wraps below zero.
// sat_hit flags the cycle an increment is lost against a full count.
module sat_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat_hit
);

    logic full;
    logic empty;

    assign full    = (count == '1);
    assign empty   = (count == '0);
    assign sat_hit = inc && !dec && !clr && full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + W'(1);
        end else if (dec && !inc && !empty) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/led_blink_driver.sv
// Stretches single-cycle events into visible LED blinks (ON, then a dark GAP).
// BLINK_QUEUE_EN: queue events arriving mid-blink; otherwise they are dropped.
module led_blink_driver
    import led_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = 10000000,
    parameter int unsigned OFF_CYCLES = 10000000,
    parameter int unsigned PEND_W     = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    led_blink_driver_if.slave bus
);

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

    led_state_t        state_q;
    led_state_t        state_d;
    logic [CNT_W-1:0]  timer_q;
    logic              led_q;
    logic              led_d;
    logic              busy_q;
    logic              busy_d;
    logic              ovf_q;
    logic [PEND_W-1:0] pend_cnt;
    logic              pend_nz;
    logic              drop;

    assign pend_nz = |pend_cnt;

`ifdef BLINK_QUEUE_EN
    logic consume;

    // Every entry into ON takes one event, whether fresh or queued.
    assign consume = (state_d == ON) && (state_q != ON);

    sat_counter #(
        .W (PEND_W)
    ) u_pend (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (bus.event_in),
        .dec     (consume),
        .clr     (bus.clr_in),
        .count   (pend_cnt),
        .sat_hit (drop)
    );
`else
    assign pend_cnt = '0;
    assign drop     = bus.event_in && !bus.clr_in &&
                      !((state_q == IDLE) || ((state_q == GAP) && (timer_q == OFF_LAST)));
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (bus.clr_in || (state_d != state_q)) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + CNT_W'(1);
            end
            led_q  <= led_d;
            busy_q <= busy_d;
            if (bus.clr_in) begin
                ovf_q <= 1'b0;
            end else if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.clr_in) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.event_in || pend_nz) state_d = ON;
                ON:   if (timer_q == ON_LAST) state_d = GAP;
                GAP:  if (timer_q == OFF_LAST) state_d = (bus.event_in || pend_nz) ? ON : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so the registers line up with it.
    always_comb begin
        led_d  = (state_d == ON);
        busy_d = (state_d != IDLE);
    end

    assign bus.led_out  = led_q;
    assign bus.busy     = busy_q;
    assign bus.pending  = pend_cnt;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_led_blink_driver.sv
// Scoreboard bench for led_blink_driver (ON=4, OFF=3, PEND_W=2).
// Expectations follow BLINK_QUEUE_EN the same way the design does.
module tb_led_blink_driver;

    localparam int unsigned ON_C  = 4;
    localparam int unsigned OFF_C = 3;
    localparam int unsigned PW    = 2;
    localparam int unsigned PMAX  = 3;

    typedef struct packed {
        logic          led;
        logic          busy;
        logic [PW-1:0] pend;
        logic          ovf;
    } obs_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    led_blink_driver_if #(.PEND_W(PW)) bus ();

    led_blink_driver #(
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C),
        .PEND_W     (PW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    obs_t exp_q[$];
    obs_t obs_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: phase 0 idle, 1 on, 2 gap; m_left counts cycles left in phase.
    int unsigned m_phase = 0;
    int unsigned m_left  = 0;
    int unsigned m_pend  = 0;
    logic        m_ovf   = 1'b0;

    task automatic model_reset();
        m_phase = 0;
        m_left  = 0;
        m_pend  = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step(input logic ev, input logic clr);
        logic start;
        logic accept;
        start  = 1'b0;
        accept = (m_phase == 0) || (m_phase == 2 && m_left == 1);
        if (clr) begin
            model_reset();
        end else begin
            case (m_phase)
                0: start = ev || (m_pend != 0);
                1: if (m_left == 1) begin m_phase = 2; m_left = OFF_C; end else m_left--;
                default: begin
                    if (m_left == 1) begin
                        if (m_pend != 0 || ev) start = 1'b1;
                        else m_phase = 0;
                    end else m_left--;
                end
            endcase
`ifdef BLINK_QUEUE_EN
            if (ev && !start) begin
                if (m_pend == PMAX) m_ovf = 1'b1;
                else m_pend++;
            end else if (!ev && start) begin
                m_pend--;
            end
`else
            if (ev && !accept) m_ovf = 1'b1;
`endif
            if (start) begin m_phase = 1; m_left = ON_C; end
        end
    endtask

    task automatic drive(input logic ev, input logic clr);
        obs_t e;
        obs_t o;
        bus.event_in = ev;
        bus.clr_in   = clr;
        model_step(ev, clr);
        e.led  = (m_phase == 1);
        e.busy = (m_phase != 0);
        e.pend = PW'(m_pend);
        e.ovf  = m_ovf;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        o.led  = bus.led_out;
        o.busy = bus.busy;
        o.pend = bus.pending;
        o.ovf  = bus.overflow;
        obs_q.push_back(o);
        bus.event_in = 1'b0;
        bus.clr_in   = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o, e;
        repeat (3) @(negedge clk);
        o = {bus.led_out, bus.busy, bus.pending, bus.overflow};
        vectors++;
        if (o !== obs_t'(0)) begin
            miscompares++;
            $display("FAIL reset_hold: led/busy/pend/ovf got %b want %b", o, obs_t'(0));
        end
        reset_n = 1'b1;
        model_reset();
        repeat (3) drive(1'b0, 1'b0);
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset_idle[%0d]: led/busy/pend/ovf got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_single();
        obs_t o, e;
        drive(1'b1, 1'b0);
        repeat (11) drive(1'b0, 1'b0);
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL single[%0d]: led/busy/pend/ovf got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_queue();
        obs_t o, e;
        logic [3:0] pat;
        pat = 4'b1101;  // pulses at cycles 0, 2, 3
        drive(1'b0, 1'b1);
        for (int unsigned c = 0; c < 4; c++) drive(pat[c], 1'b0);
        repeat (22) drive(1'b0, 1'b0);
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL queue[%0d]: led/busy/pend/ovf got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_saturate();
        obs_t o, e;
        drive(1'b0, 1'b1);
        repeat (5) drive(1'b1, 1'b0);
        repeat (32) drive(1'b0, 1'b0);
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL saturate[%0d]: led/busy/pend/ovf got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        repeat (6) drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);  // lands on the final GAP cycle
        repeat (14) drive(1'b0, 1'b0);
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: led/busy/pend/ovf got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_clear();
        obs_t o, e;
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b1);
        repeat (12) drive(1'b0, 1'b0);
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL clear[%0d]: led/busy/pend/ovf got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t o, e;
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        o = {bus.led_out, bus.busy, bus.pending, bus.overflow};
        vectors++;
        if (o !== obs_t'(0)) begin
            miscompares++;
            $display("FAIL async_reset: led/busy/pend/ovf got %b want %b", o, obs_t'(0));
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (12) drive(1'b0, 1'b0);
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL async_reset_seq[%0d]: led/busy/pend/ovf got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        drive(1'b0, 1'b1);
        for (int c = 0; c < 120; c++) begin
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0));
        end
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL random[%0d]: led/busy/pend/ovf got %b want %b", i, o, e);
            end
        end
    endtask

    initial begin
        bus.event_in = 1'b0;
        bus.clr_in   = 1'b0;
        test_reset();
        test_single();
        test_queue();
        test_saturate();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_blink_driver.md
# led_blink_driver

Output-side counterpart to the push-button input conditioner. It converts single-cycle event pulses from the FPU control logic into blinks a human can see on a board LED. Each accepted event produces exactly one blink: LED on for `ON_CYCLES`, then off for at least `OFF_CYCLES`. Events that arrive while a blink is in progress are queued in a saturating counter and replayed one after another.

## Interface
Parameters:
- `ON_CYCLES`, default 10000000: LED-on duration in clk cycles (100 ms at 100 MHz). Legal range 1..2^CNT_W.
- `OFF_CYCLES`, default 10000000: minimum dark gap after each blink. Legal range 1..2^CNT_W.
- `PEND_W`, default 4: width of the pending-event counter, so up to 2^PEND_W-1 events are queued.

Ports:
- `clk` input, 1: single system clock, rising edge.
- `reset_n` input, 1: asynchronous, active-low reset.
- `event_in` input, 1: one-cycle event pulse, synchronous to clk.
- `clr_in` input, 1: synchronous abort; drops the queue and clears the overflow flag.
- `led_out` output, 1: LED drive, registered, active-high.
- `busy` output, 1: high while state is ON or GAP.
- `pending` output, PEND_W: number of queued events not yet blinked.
- `overflow` output, 1: sticky flag; set whenever an event is dropped.

## Operation
- FSM states: IDLE, ON, GAP. The timer is a single CNT_W=24-bit up-counter that is cleared on every state change.
- IDLE
  - `led_out` is 0.
  - If `event_in` or `pending`≠0: go to ON.
- ON
  - `led_out` is 1.
  - When timer = ON_CYCLES-1: go to GAP.
- GAP
  - `led_out` is 0.
  - When timer = OFF_CYCLES-1: if `pending`≠0 or `event_in`, go to ON; otherwise go to IDLE.
- Consume: every transition into ON consumes one event.
- Pending update: `pending_next` = `pending` + `event_in` − consume.
  - Entry into ON requires at least one event available, so the counter never underflows.
  - An event and a consume in the same cycle leave `pending` unchanged.
- Saturation: if `pending` = 2^PEND_W-1, `event_in`=1 and there is no consume, then `pending` holds its value and `overflow` is set.
- `clr_in` has priority over everything else. On the next edge:
  - state goes to IDLE, timer to 0, `led_out` to 0;
  - `pending` and `overflow` go to 0;
  - an `event_in` in the same cycle is discarded and does not set overflow.
- Reset values: state IDLE, timer 0, `led_out` 0, `busy` 0, `pending` 0, `overflow` 0.
- Reset asserted mid-blink takes effect immediately (asynchronous). No partial blink resumes after release.

## Timing
- `event_in` sampled high in IDLE at edge N: `led_out` is 1 from edge N+1.
- `led_out` is high for exactly ON_CYCLES cycles.
- After each blink, `led_out` is low for exactly OFF_CYCLES cycles before the next queued blink starts, with no extra idle cycle between them.
- Back-to-back queued blinks therefore have a period of ON_CYCLES+OFF_CYCLES.
- `busy` is registered and aligned with `led_out` entering ON. It drops the cycle the FSM returns to IDLE.
- `pending` and `overflow` update one edge after the causing input.

## Configuration
- `BLINK_QUEUE_EN` defined:
  - Queueing is as described under Operation.
- `BLINK_QUEUE_EN` undefined:
  - No counter is instantiated and `pending` is tied to 0.
  - `event_in` is accepted only in IDLE, or at the final GAP cycle.
  - An event arriving during ON or any earlier GAP cycle is dropped and sets `overflow`.
  - All other timing is unchanged.

## Structure
- Package `led_pkg` holds:
  - the state typedef (IDLE/ON/GAP, 2 bits);
  - `CNT_W` = 24.
- Sub-module `sat_counter` is a parameterised up/down saturating counter. It has `inc`, `dec` and `clr` inputs, a `count` output and a `sat_hit` output. It is used for `pending`.
- The FSM and the timer live in the top module.

## Test plan
Use ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2 unless noted.
- Reset, then one `event_in` pulse at cycle 0 -> `led_out`=1 on cycles 1-4 and 0 from cycle 5; `busy` returns to 0 at cycle 8; `pending` stays 0.
- Three pulses at cycles 0, 2, 3 -> three blinks starting at cycles 1, 8 and 15; `pending` reads 2 after cycle 3 and reaches 0 at cycle 15; `overflow`=0.
- Five pulses during the first blink -> `pending` saturates at 3 and `overflow`=1 (sticky); four blinks total.
- `event_in` together with the last GAP cycle -> the next ON starts with no idle gap; `pending` is unchanged.
- `clr_in` in the middle of ON with `event_in` high in the same cycle -> next cycle `led_out`=0, state IDLE, `pending`=0, `overflow`=0; no further blinks.
- `reset_n` low in the middle of a blink, then released -> all outputs go to 0 asynchronously; no blink after release.
- With `BLINK_QUEUE_EN` undefined, a pulse during ON -> dropped, `overflow`=1, exactly one blink.
